// File: rtl/led_arbiter.sv
// ============================================================================
// Module      : led_arbiter
// Description : Shares eight indicator LEDs between three prioritised
//               requesters. Each grant is held for a minimum time. A
//               higher-priority requester can preempt once that hold expires.
//               When no requester owns the LEDs, a heartbeat blinks on LED 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_arbiter #(
    parameter int HOLD_CYCLES = 1024,
    parameter int BLINK_BITS  = 22
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [7:0] pattern0,
    input  logic [7:0] pattern1,
    input  logic [7:0] pattern2,
    output logic [2:0] grant,
    output logic [7:0] leds,
    output logic       busy
);

    // The hold counter only ever needs to reach HOLD_CYCLES-1.
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_owner;
    logic [1:0]            w_owner_next;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_next;
    logic [BLINK_BITS-1:0] r_hb_cnt;
    logic                  r_blink;
    logic                  w_blink_next;
    logic [2:0]            r_grant;
    logic [2:0]            w_grant_next;
    logic                  r_busy;
    logic [7:0]            r_leds;
    logic [7:0]            w_leds_next;
    logic [1:0]            w_first;

    // The heartbeat toggles on the edge where the counter wraps.
    // The IDLE LED value uses the post-edge blink, so LED 0 matches blink.
    assign w_blink_next = (&r_hb_cnt) ? ~r_blink : r_blink;

    // Pick the highest-priority requester, which is the lowest asserted index.
    always_comb begin
        w_first = 2'd2;
        if (req[0]) begin
            w_first = 2'd0;
        end else if (req[1]) begin
            w_first = 2'd1;
        end
    end

    // Next-state logic: grant, hold countdown, and the re-arbitration after expiry.
    // After expiry, the lowest asserted index always wins. If that index is
    // the current owner, the owner simply stays and the hold counter stays at zero.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_next = S_OWNED;
                    w_owner_next = w_first;
                    w_hold_next  = c_HOLD_INIT;
                end
            end
            S_OWNED: begin
                if (r_hold_cnt != '0) begin
                    w_hold_next = r_hold_cnt - c_HOLD_W'(1);
                end else if (|req) begin
                    if (w_first != r_owner) begin
                        w_owner_next = w_first;
                        w_hold_next  = c_HOLD_INIT;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so grant and leds change on the same edge.
    always_comb begin
        w_grant_next = 3'b000;
        w_leds_next  = {7'b0, w_blink_next};
        if (w_state_next == S_OWNED) begin
            case (w_owner_next)
                2'd0: begin
                    w_grant_next = 3'b001;
                    w_leds_next  = pattern0;
                end
                2'd1: begin
                    w_grant_next = 3'b010;
                    w_leds_next  = pattern1;
                end
                default: begin
                    w_grant_next = 3'b100;
                    w_leds_next  = pattern2;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_owner    <= 2'd0;
            r_hold_cnt <= '0;
            r_hb_cnt   <= '0;
            r_blink    <= 1'b0;
            r_grant    <= 3'b000;
            r_busy     <= 1'b0;
            r_leds     <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_hold_cnt <= w_hold_next;
            r_hb_cnt   <= r_hb_cnt + BLINK_BITS'(1);
            r_blink    <= w_blink_next;
            r_grant    <= w_grant_next;
            r_busy     <= |w_grant_next;
            r_leds     <= w_leds_next;
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign leds  = r_leds;

endmodule

`default_nettype wire
